ahb_master_req_ctrl: RTL and testbench

- Master-side bus-request controller; the initiator counterpart of the per-slave AHB arbiter.
- Takes burst commands from a master core and drives hreq/hburst toward the arbiter.
- Waits for hgrant, counts accepted beats against the burst length, and releases hreq after the last beat.
- Emits per-beat strobes to the master datapath and flags requests starved beyond a timeout.

---
 rtl/ahb_master_req_ctrl_pkg.sv | 39 +++
 rtl/ahb_req_watchdog.sv | 34 +++
 rtl/ahb_master_req_ctrl.sv | 107 ++++++++++
 tb/tb_ahb_master_req_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_master_req_ctrl_pkg.sv
// Shared AHB types and the burst-length decode used by both master and arbiter.
// Pure declarations; no latency, no flow control.
package ahb_master_req_ctrl_pkg;

    typedef enum logic [2:0] {
        SINGLE = 3'd0,
        INCR   = 3'd1,
        WRAP4  = 3'd2,
        INCR4  = 3'd3,
        WRAP8  = 3'd4,
        INCR8  = 3'd5,
        WRAP16 = 3'd6,
        INCR16 = 3'd7
    } hburst_type;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        NONSEQ = 2'd2,
        SEQ    = 2'd3
    } htrans_type;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_BURST = 2'd2
    } req_state_t;

    // Index of the final beat; undefined-length INCR is treated as a single beat.
    function automatic logic [3:0] burst_limit(input hburst_type b);
        case (b)
            WRAP4, INCR4:   burst_limit = 4'd3;
            WRAP8, INCR8:   burst_limit = 4'd7;
            WRAP16, INCR16: burst_limit = 4'd15;
            default:        burst_limit = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_req_watchdog.sv
// Request-starvation counter: clear/load/enable, expire is combinational on the LIMIT-th enabled cycle.
// LIMIT=0 disables expiry; no flow control.
module ahb_req_watchdog #(
    parameter int TMO_W = 8,
    parameter int LIMIT = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [TMO_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             expire_o
);

    localparam logic [TMO_W-1:0] LIM_M1 = TMO_W'(LIMIT - 1);

    logic [TMO_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)       cnt_d = '0;
        else if (load_i) cnt_d = load_val_i;
        else if (en_i)   cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign expire_o = (LIMIT != 0) && en_i && !clr_i && (cnt_q == LIM_M1);

endmodule

// File: rtl/ahb_master_req_ctrl.sv
// Master-side AHB bus-request FSM: cmd handshake -> hreq next cycle, hreq drops on the edge after the last beat.
// cmd_ready only in IDLE; beats advance on hgrant, wait states hold beat_idx; starved requests abort after REQ_TIMEOUT.
module ahb_master_req_ctrl
    import ahb_master_req_ctrl_pkg::*;
#(
    parameter int REQ_TIMEOUT = 255,
    parameter int TMO_W       = 8
) (
    input  logic       hclk,
    input  logic       hreset,
    input  logic       cmd_valid,
    input  hburst_type cmd_burst,
    output logic       cmd_ready,
    output logic       hreq,
    output hburst_type hburst,
    input  logic       hgrant,
    output htrans_type htrans,
    output logic       beat_ack,
    output logic [3:0] beat_idx,
    output logic       beat_last,
    output logic       busy,
    output logic       timeout_err
);

    req_state_t state_q;
    hburst_type burst_q;
    logic [3:0] beat_idx_q;
    logic       tmo_q;
    logic [3:0] lim;
    logic       wd_expire;

    assign lim = burst_limit(burst_q);

    ahb_req_watchdog #(
        .TMO_W (TMO_W),
        .LIMIT (REQ_TIMEOUT)
    ) u_wdog (
        .clk_i      (hclk),
        .rst_i      (hreset),
        .clr_i      (state_q == ST_IDLE),
        .load_i     (1'b0),
        .load_val_i ({TMO_W{1'b0}}),
        .en_i       (state_q == ST_REQ),
        .expire_o   (wd_expire)
    );

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q    <= ST_IDLE;
            burst_q    <= SINGLE;
            beat_idx_q <= 4'd0;
            tmo_q      <= 1'b0;
        end else begin
            tmo_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // hgrant here is the registered-grant tail of the previous burst
                    if (cmd_valid) begin
                        burst_q    <= cmd_burst;
                        beat_idx_q <= 4'd0;
                        state_q    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // A grant in the expiry cycle still wins
                    if (hgrant) begin
                        if (lim == 4'd0) begin
                            state_q <= ST_IDLE;
                        end else begin
                            beat_idx_q <= 4'd1;
                            state_q    <= ST_BURST;
                        end
                    end else if (wd_expire) begin
                        tmo_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                ST_BURST: begin
                    if (hgrant) begin
                        if (beat_idx_q == lim) state_q    <= ST_IDLE;
                        else                   beat_idx_q <= beat_idx_q + 4'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign cmd_ready   = (state_q == ST_IDLE);
    assign hreq        = busy;
    assign hburst      = burst_q;
    assign beat_idx    = beat_idx_q;
    assign beat_last   = busy && (beat_idx_q == lim);
    assign beat_ack    = hgrant && busy;
    assign timeout_err = tmo_q;

    always_comb begin
        htrans = IDLE;
        case (state_q)
            ST_REQ:   htrans = NONSEQ;
            ST_BURST: htrans = SEQ;
            default:  htrans = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ahb_master_req_ctrl.sv
// Scenario bench for ahb_master_req_ctrl with a beat scoreboard checked on every beat_ack.
module tb_ahb_master_req_ctrl;
    import ahb_master_req_ctrl_pkg::*;

    logic       hclk = 1'b0;
    logic       hreset;
    logic       cmd_valid;
    hburst_type cmd_burst;
    logic       cmd_ready;
    logic       hreq;
    hburst_type hburst;
    logic       hgrant;
    htrans_type htrans;
    logic       beat_ack;
    logic [3:0] beat_idx;
    logic       beat_last;
    logic       busy;
    logic       timeout_err;

    typedef struct packed {
        logic [3:0] idx;
        logic       last;
        htrans_type tr;
        hburst_type b;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_got, mon_exp;
    int    n_pass  = 0;
    int    n_total = 0;

    localparam logic [14:0] RESET_VEC = 15'h0001;

    always #5 hclk = ~hclk;

    ahb_master_req_ctrl #(
        .REQ_TIMEOUT (4),
        .TMO_W       (8)
    ) dut (
        .hclk        (hclk),
        .hreset      (hreset),
        .cmd_valid   (cmd_valid),
        .cmd_burst   (cmd_burst),
        .cmd_ready   (cmd_ready),
        .hreq        (hreq),
        .hburst      (hburst),
        .hgrant      (hgrant),
        .htrans      (htrans),
        .beat_ack    (beat_ack),
        .beat_idx    (beat_idx),
        .beat_last   (beat_last),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    function automatic int tb_lim(input hburst_type b);
        case (b)
            WRAP4, INCR4:   return 3;
            WRAP8, INCR8:   return 7;
            WRAP16, INCR16: return 15;
            default:        return 0;
        endcase
    endfunction

    // Scoreboard: every accepted beat must match the next expected beat
    always @(negedge hclk) begin
        if (!hreset && beat_ack) begin
            n_total++;
            mon_got = {beat_idx, beat_last, htrans, hburst};
            if (exp_q.size() == 0) begin
                $display("FAIL beat_unexpected: got idx=%0d last=%0d trans=%0d burst=%0d, required no beat",
                         beat_idx, beat_last, htrans, hburst);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp)
                    $display("FAIL beat: got idx=%0d last=%0d trans=%0d burst=%0d, required idx=%0d last=%0d trans=%0d burst=%0d",
                             mon_got.idx, mon_got.last, mon_got.tr, mon_got.b,
                             mon_exp.idx, mon_exp.last, mon_exp.tr, mon_exp.b);
                else
                    n_pass++;
            end
        end
    end

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    // Present one command; returns one step into the first REQ cycle
    task automatic issue(input hburst_type b, input bit push);
        beat_t e;
        tick();
        cmd_valid = 1'b1;
        cmd_burst = b;
        hgrant    = 1'b0;
        if (push) begin
            for (int i = 0; i <= tb_lim(b); i++) begin
                e.idx  = 4'(i);
                e.last = (i == tb_lim(b));
                e.tr   = (i == 0) ? NONSEQ : SEQ;
                e.b    = b;
                exp_q.push_back(e);
            end
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    // Drive hgrant from a per-cycle mask until the DUT goes idle (or the mask is exhausted)
    task automatic run_grants(input logic [63:0] gmask, output int acks, output int cyc, output int tmo);
        acks = 0;
        cyc  = 0;
        tmo  = 0;
        for (int c = 0; c < 64; c++) begin
            hgrant = gmask[c];
            @(negedge hclk);
            if (timeout_err) tmo++;
            if (!busy) break;
            cyc++;
            if (beat_ack) acks++;
            tick();
        end
    endtask

    task automatic test_reset();
        hreset    = 1'b1;
        cmd_valid = 1'b0;
        cmd_burst = SINGLE;
        hgrant    = 1'b0;
        @(negedge hclk);
        @(negedge hclk);
        n_total++;
        if ({hreq, hburst, htrans, beat_idx, beat_last, beat_ack, busy, timeout_err, cmd_ready} !== RESET_VEC)
            $display("FAIL reset_outputs: got %h required %h",
                     {hreq, hburst, htrans, beat_idx, beat_last, beat_ack, busy, timeout_err, cmd_ready}, RESET_VEC);
        else n_pass++;
        tick();
        hreset = 1'b0;
    endtask

    task automatic test_single();
        int a, c, t;
        issue(SINGLE, 1'b1);
        run_grants(64'hC, a, c, t);
        n_total++;
        if (a !== 1 || c !== 3 || t !== 0)
            $display("FAIL single_counts: got acks=%0d hreq_cycles=%0d tmo=%0d required 1/3/0", a, c, t);
        else n_pass++;
        n_total++;
        if ({beat_ack, hreq, cmd_ready} !== 3'b001)
            $display("FAIL single_trailing_grant: got ack/hreq/ready=%b required 001", {beat_ack, hreq, cmd_ready});
        else n_pass++;
        tick();
        hgrant = 1'b0;
    endtask

    task automatic test_incr4();
        int a, c, t;
        issue(INCR4, 1'b1);
        run_grants(~64'h1, a, c, t);
        n_total++;
        if (a !== 4 || c !== 5 || t !== 0)
            $display("FAIL incr4_counts: got acks=%0d hreq_cycles=%0d tmo=%0d required 4/5/0", a, c, t);
        else n_pass++;
        n_total++;
        if ({beat_ack, hreq, busy} !== 3'b000)
            $display("FAIL incr4_release: got ack/hreq/busy=%b required 000", {beat_ack, hreq, busy});
        else n_pass++;
        tick();
        hgrant = 1'b0;
    endtask

    task automatic test_wrap8_wait();
        int acks = 0;
        int hb_bad = 0;
        issue(WRAP8, 1'b1);
        for (int c = 0; c < 40; c++) begin
            hgrant    = !(c == 3 || c == 4);
            cmd_burst = (c % 2 != 0) ? INCR : SINGLE;
            @(negedge hclk);
            if (!busy) break;
            if (hburst !== WRAP8) hb_bad++;
            if (c == 3 || c == 4) begin
                n_total++;
                if (beat_idx !== 4'd3 || hreq !== 1'b1)
                    $display("FAIL wrap8_wait_hold: cycle %0d got idx=%0d hreq=%b required idx=3 hreq=1", c, beat_idx, hreq);
                else n_pass++;
            end
            if (beat_ack) acks++;
            tick();
        end
        n_total++;
        if (acks !== 8) $display("FAIL wrap8_beats: got %0d required 8", acks);
        else n_pass++;
        n_total++;
        if (hb_bad !== 0) $display("FAIL wrap8_hburst_stable: got %0d bad cycles required 0", hb_bad);
        else n_pass++;
        tick();
        hgrant    = 1'b0;
        cmd_burst = SINGLE;
    endtask

    task automatic test_timeout();
        int tmo_cnt = 0;
        int tmo_at  = -1;
        int hreq_cyc = 0;
        logic [1:0] rdy_busy_at4 = 2'b00;
        issue(INCR4, 1'b0);
        for (int c = 0; c < 8; c++) begin
            hgrant = 1'b0;
            @(negedge hclk);
            if (timeout_err) begin
                tmo_cnt++;
                if (tmo_at < 0) tmo_at = c;
            end
            if (hreq) hreq_cyc++;
            if (c == 4) rdy_busy_at4 = {cmd_ready, busy};
            tick();
        end
        n_total++;
        if (tmo_cnt !== 1 || tmo_at !== 4)
            $display("FAIL timeout_pulse: got count=%0d at=%0d required count=1 at=4", tmo_cnt, tmo_at);
        else n_pass++;
        n_total++;
        if (rdy_busy_at4 !== 2'b10 || hreq_cyc !== 4)
            $display("FAIL timeout_idle: got ready/busy=%b hreq_cycles=%0d required 10/4", rdy_busy_at4, hreq_cyc);
        else n_pass++;
    endtask

    task automatic test_grant_vs_expiry();
        int a, c, t;
        issue(SINGLE, 1'b1);
        run_grants(64'h18, a, c, t);
        n_total++;
        if (a !== 1 || c !== 4 || t !== 0)
            $display("FAIL grant_wins: got acks=%0d hreq_cycles=%0d tmo=%0d required 1/4/0", a, c, t);
        else n_pass++;
        tick();
        hgrant = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        int a, c, t;
        bit hit = 1'b0;
        issue(INCR16, 1'b1);
        for (int k = 0; k < 30; k++) begin
            hgrant = 1'b1;
            @(negedge hclk);
            if (beat_ack && beat_idx == 4'd9) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        #1;
        hreset = 1'b1;
        #1;
        n_total++;
        if (!hit || {hreq, hburst, htrans, beat_idx, beat_last, beat_ack, busy, timeout_err, cmd_ready} !== RESET_VEC)
            $display("FAIL reset_mid_burst: got hit=%0d outs=%h required hit=1 outs=%h", hit,
                     {hreq, hburst, htrans, beat_idx, beat_last, beat_ack, busy, timeout_err, cmd_ready}, RESET_VEC);
        else n_pass++;
        n_total++;
        if (exp_q.size() !== 6) $display("FAIL reset_dropped_beats: got %0d pending required 6", exp_q.size());
        else n_pass++;
        exp_q.delete();
        tick();
        hgrant = 1'b0;
        hreset = 1'b0;
        issue(SINGLE, 1'b1);
        run_grants(64'h3, a, c, t);
        n_total++;
        if (a !== 1 || c !== 1 || t !== 0)
            $display("FAIL after_reset_single: got acks=%0d hreq_cycles=%0d tmo=%0d required 1/1/0", a, c, t);
        else n_pass++;
        tick();
        hgrant = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_incr4();
        test_wrap8_wait();
        test_timeout();
        test_grant_vs_expiry();
        test_reset_mid_burst();
        tick();
        n_total++;
        if (exp_q.size() !== 0) $display("FAIL scoreboard_drained: got %0d pending required 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: simulation did not complete");
        $fatal(1, "simulation time limit");
    end

endmodule
